// File: rtl/rf_pkg.sv
// Shared types and defaults for the multiport register file.
// Holds the FSM state encoding and the default geometry.
package rf_pkg;

    typedef enum logic [0:0] {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } state_t;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    function automatic int rf_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-entry pending-write bits: writes clear, claims set, and a claim
// outranks a same-cycle write because it names a newer producer.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_WR-1:0]          clr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   clr_addr,
    input  logic                       set_en,
    input  logic [ADDR_W-1:0]          set_addr,
    output logic [(1<<ADDR_W)-1:0]     busy
);

    localparam int DEPTH = rf_depth(ADDR_W);

    logic [DEPTH-1:0] busy_d;

    always_comb begin
        busy_d = busy;
        for (int w = 0; w < NUM_WR; w++) begin
            if (clr_en[w]) begin
                busy_d[clr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (set_en) begin
            busy_d[set_addr] = 1'b1;
        end
        // Entry 0 is a constant when hardwired, so it can never be pending.
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_d;
        end
    end

endmodule

// File: rtl/rf_multiport.sv
// Parametrised multiport register file with bypass, zero register,
// pending-write scoreboard and a post-reset clear sweep.
module rf_multiport
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic                       claim_en,
    input  logic [ADDR_W-1:0]          claim_addr,
    output logic                       ready,
    output state_t                     dbg_state
);

    localparam int DEPTH = rf_depth(ADDR_W);
    localparam logic [ADDR_W:0] LAST_ENTRY = (ADDR_W+1)'(DEPTH - 1);

    // Valid/ready: a write or claim is taken on any rising edge where its
    // enable is high and ready is high; while ready is low they are dropped.

    state_t                   state;
    logic [ADDR_W:0]          sweep_cnt;
    logic [DATA_W-1:0]        mem [DEPTH];
    logic [DEPTH-1:0]         busy;
    logic                     run;
    logic [NUM_WR-1:0]        wr_ok;
    logic                     claim_ok;
    logic [NUM_RD-1:0]        fwd_hit;
    logic [NUM_RD*DATA_W-1:0] fwd_data;
    logic [NUM_RD-1:0]        claim_hit;
    logic [NUM_RD*DATA_W-1:0] rd_data_d;
    logic [NUM_RD-1:0]        rd_busy_d;

    assign run       = (state == RF_RUN);
    assign ready     = run;
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RF_INIT;
            sweep_cnt <= '0;
        end else if (state == RF_INIT) begin
            sweep_cnt <= sweep_cnt + 1'b1;
            if (sweep_cnt == LAST_ENTRY) begin
                state <= RF_RUN;
            end
        end
    end

    always_comb begin
        wr_ok = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            wr_ok[w] = run && wr_en[w] &&
                       !(ZERO_REG != 0 && wr_addr[w*ADDR_W +: ADDR_W] == '0);
        end
        claim_ok = run && claim_en && !(ZERO_REG != 0 && claim_addr == '0);
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .clr_en   (wr_en & {NUM_WR{run}}),
        .clr_addr (wr_addr),
        .set_en   (claim_en & run),
        .set_addr (claim_addr),
        .busy     (busy)
    );

    // Ascending port order makes the highest-indexed writer win a collision.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[sweep_cnt[ADDR_W-1:0]] <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_ok[w]) begin
                    mem[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        fwd_hit   = '0;
        fwd_data  = '0;
        claim_hit = '0;
        rd_data_d = '0;
        rd_busy_d = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_ok[w] && wr_addr[w*ADDR_W +: ADDR_W] == rd_addr[p*ADDR_W +: ADDR_W]) begin
                    fwd_hit[p] = 1'b1;
                    fwd_data[p*DATA_W +: DATA_W] = wr_data[w*DATA_W +: DATA_W];
                end
            end
            claim_hit[p] = claim_ok && (claim_addr == rd_addr[p*ADDR_W +: ADDR_W]);
            if (!run || (ZERO_REG != 0 && rd_addr[p*ADDR_W +: ADDR_W] == '0)) begin
                rd_data_d[p*DATA_W +: DATA_W] = '0;
                rd_busy_d[p] = 1'b0;
            end else if (BYPASS != 0 && fwd_hit[p]) begin
                rd_data_d[p*DATA_W +: DATA_W] = fwd_data[p*DATA_W +: DATA_W];
                rd_busy_d[p] = claim_hit[p];
            end else begin
                rd_data_d[p*DATA_W +: DATA_W] = mem[rd_addr[p*ADDR_W +: ADDR_W]];
                rd_busy_d[p] = busy[rd_addr[p*ADDR_W +: ADDR_W]];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
            rd_busy <= '0;
        end else begin
            rd_data <= rd_data_d;
            rd_busy <= rd_busy_d;
        end
    end

endmodule

// File: tb/tb_rf_multiport.sv
// Bench for rf_multiport: a bypassing and a non-bypassing instance share
// stimulus and are compared against an array-based model of the register file.
module tb_rf_multiport;
    import rf_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int NW    = 2;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [NR*AW-1:0] rd_addr;
    logic [NW-1:0]    wr_en;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;
    logic             claim_en;
    logic [AW-1:0]    claim_addr;

    logic [NR*DW-1:0] rd_data_b, rd_data_n;
    logic [NR-1:0]    rd_busy_b, rd_busy_n;
    logic             ready_b, ready_n;
    state_t           st_b, st_n;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mem_m  [DEPTH];
    logic          busy_m [DEPTH];

    always #5 clk = ~clk;

    rf_multiport #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .claim_en(claim_en),
        .claim_addr(claim_addr), .ready(ready_b), .dbg_state(st_b)
    );

    rf_multiport #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(0), .ZERO_REG(1)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .claim_en(claim_en),
        .claim_addr(claim_addr), .ready(ready_n), .dbg_state(st_n)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog expired before the summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        rd_addr    = '0;
        wr_en      = '0;
        wr_addr    = '0;
        wr_data    = '0;
        claim_en   = 1'b0;
        claim_addr = '0;
    endtask

    task automatic rnd_inputs(input int amax);
        for (int p = 0; p < NR; p++) rd_addr[p*AW +: AW] = AW'($urandom_range(0, amax));
        for (int w = 0; w < NW; w++) begin
            wr_addr[w*AW +: AW] = AW'($urandom_range(0, amax));
            wr_data[w*DW +: DW] = $urandom;
        end
        wr_en      = NW'($urandom);
        claim_en   = 1'($urandom);
        claim_addr = AW'($urandom_range(0, amax));
    endtask

    task automatic reset_model();
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i]  = '0;
            busy_m[i] = 1'b0;
        end
    endtask

    // Called just after rst has fallen: the file must stay not-ready for one
    // edge per entry, ignoring writes and claims, and then come up clean.
    task automatic do_sweep(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("%s_ready_b_%0d", tag, i), 64'(ready_b), 64'd0);
            check($sformatf("%s_ready_n_%0d", tag, i), 64'(ready_n), 64'd0);
            check($sformatf("%s_state_%0d", tag, i), 64'(st_b), 64'(RF_INIT));
            check($sformatf("%s_rdata_%0d", tag, i), 64'(rd_data_b), 64'd0);
            check($sformatf("%s_rbusy_%0d", tag, i), 64'({rd_busy_b, rd_busy_n}), 64'd0);
            rnd_inputs(DEPTH - 1);
            @(posedge clk);
            #1;
        end
        check($sformatf("%s_ready_up_b", tag), 64'(ready_b), 64'd1);
        check($sformatf("%s_ready_up_n", tag), 64'(ready_n), 64'd1);
        check($sformatf("%s_state_run", tag), 64'(st_b), 64'(RF_RUN));
        set_idle();
        reset_model();
    endtask

    // One RUN cycle: predict both instances from the model, apply, compare.
    task automatic do_cycle(input string tag);
        logic [DW-1:0] ed_b [NR];
        logic [DW-1:0] ed_n [NR];
        logic          eb_b [NR];
        logic          eb_n [NR];
        logic [AW-1:0] a;
        logic [AW-1:0] wa;
        for (int p = 0; p < NR; p++) begin
            a = rd_addr[p*AW +: AW];
            ed_n[p] = (a == 0) ? '0 : mem_m[a];
            eb_n[p] = (a == 0) ? 1'b0 : busy_m[a];
            ed_b[p] = ed_n[p];
            eb_b[p] = eb_n[p];
            if (a != 0) begin
                for (int w = 0; w < NW; w++) begin
                    if (wr_en[w] && wr_addr[w*AW +: AW] == a) begin
                        ed_b[p] = wr_data[w*DW +: DW];
                        eb_b[p] = claim_en && (claim_addr == a);
                    end
                end
            end
        end
        for (int w = 0; w < NW; w++) begin
            wa = wr_addr[w*AW +: AW];
            if (wr_en[w] && wa != 0) begin
                mem_m[wa]  = wr_data[w*DW +: DW];
                busy_m[wa] = 1'b0;
            end
        end
        if (claim_en && claim_addr != 0) busy_m[claim_addr] = 1'b1;
        @(posedge clk);
        #1;
        for (int p = 0; p < NR; p++) begin
            check($sformatf("%s_byp_data%0d", tag, p), 64'(rd_data_b[p*DW +: DW]), 64'(ed_b[p]));
            check($sformatf("%s_byp_busy%0d", tag, p), 64'(rd_busy_b[p]), 64'(eb_b[p]));
            check($sformatf("%s_nob_data%0d", tag, p), 64'(rd_data_n[p*DW +: DW]), 64'(ed_n[p]));
            check($sformatf("%s_nob_busy%0d", tag, p), 64'(rd_busy_n[p]), 64'(eb_n[p]));
        end
        check($sformatf("%s_ready", tag), 64'({ready_b, ready_n}), 64'b11);
    endtask

    initial begin
        set_idle();
        reset_model();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'({ready_b, ready_n}), 64'd0);
        check("rst_rdata", 64'(rd_data_b | rd_data_n), 64'd0);
        check("rst_rbusy", 64'({rd_busy_b, rd_busy_n}), 64'd0);
        check("rst_state", 64'({st_b, st_n}), 64'd0);
        rst = 1'b0;
        do_sweep("sweep0");

        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = {AW'(DEPTH - 1 - i), AW'(i)};
            do_cycle($sformatf("clear_rd%0d", i));
        end

        set_idle();
        wr_en = 2'b01; wr_addr[0 +: AW] = 5; wr_data[0 +: DW] = 32'hDEADBEEF;
        do_cycle("wr5");
        set_idle();
        rd_addr[AW +: AW] = 5;
        do_cycle("rd5_p1");

        set_idle();
        wr_en = 2'b01; wr_addr[0 +: AW] = 0; wr_data[0 +: DW] = 32'h1234;
        do_cycle("wr0");
        set_idle();
        do_cycle("rd0");

        set_idle();
        wr_en = 2'b11;
        wr_addr = {AW'(7), AW'(7)};
        wr_data = {32'h22, 32'h11};
        do_cycle("wr7_collide");
        set_idle();
        rd_addr = {AW'(7), AW'(7)};
        do_cycle("rd7");

        set_idle();
        wr_en = 2'b01; wr_addr[0 +: AW] = 3; wr_data[0 +: DW] = 32'hA5A5;
        rd_addr[0 +: AW] = 3;
        do_cycle("bypass3");

        set_idle();
        claim_en = 1'b1; claim_addr = 9;
        do_cycle("claim9");
        set_idle();
        rd_addr = {AW'(9), AW'(9)};
        do_cycle("rd9_busy");
        set_idle();
        wr_en = 2'b10; wr_addr[AW +: AW] = 9; wr_data[DW +: DW] = 32'hCAFE;
        do_cycle("wr9");
        set_idle();
        rd_addr = {AW'(9), AW'(9)};
        do_cycle("rd9_free");
        set_idle();
        wr_en = 2'b01; wr_addr[0 +: AW] = 9; wr_data[0 +: DW] = 32'hBEEF;
        claim_en = 1'b1; claim_addr = 9;
        rd_addr = {AW'(9), AW'(9)};
        do_cycle("claimwr9");
        set_idle();
        rd_addr = {AW'(9), AW'(9)};
        do_cycle("rd9_claimwr");

        for (int i = 0; i < 400; i++) begin
            rnd_inputs((i % 2 == 0) ? 7 : DEPTH - 1);
            do_cycle($sformatf("rand%0d", i));
        end

        set_idle();
        wr_en = 2'b01; wr_addr[0 +: AW] = 4; wr_data[0 +: DW] = 32'h55;
        do_cycle("wr4");
        set_idle();
        rd_addr = {AW'(4), AW'(4)};
        do_cycle("rd4");
        rst = 1'b1;
        #1;
        check("midrst_ready", 64'({ready_b, ready_n}), 64'd0);
        check("midrst_rdata", 64'(rd_data_b | rd_data_n), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_sweep("sweep1");
        set_idle();
        rd_addr = {AW'(4), AW'(4)};
        do_cycle("rd4_after_rst");
        check("rd4_after_rst_direct", 64'(rd_data_b[0 +: DW]), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
